qspi_host: RTL and testbench
============================

Name: qspi_host

Overview:
- QSPI initiator that drives the QSPI => parallel NOR bridge from the host side.
- Takes one transaction request (command, address, direction, word count) over a valid/ready handshake.
- Produces the complete QSPI frame on SCK/SCE/IO: command, 32-bit address, dummy clocks and 16-bit data words.
- Used as the bench and FPGA-side initiator, and to exercise the bridge's QSPI slave end to end.

Parameters:
- CLKDIV, 2, SCK half-period in clk_i cycles (>=1).
- DUMMY, 8, dummy SCK cycles inserted before read data (0..31).
- LENBITS, 8, width of the word-count field.
- CSHIGH, 4, minimum clk_i cycles SCE stays high between frames.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  host idle and able to accept a request
- req_cmd_i  in  8  command byte
- req_addr_i  in  32  address
- req_write_i  in  1  1 = write data phase, 0 = read data phase
- req_len_i  in  LENBITS  number of 16-bit data words; 0 = no data phase
- wr_data_i  in  16  write word
- wr_valid_i  in  1  write word available
- wr_ready_o  out  1  one-cycle pulse when the write word is latched
- rd_data_o  out  16  read word
- rd_valid_o  out  1  one-cycle pulse when rd_data_o is new
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse when SCE returns high
- qspi_sck_o  out  1  SPI clock, idles low (mode 0)
- qspi_sce_o  out  1  chip enable, active low
- qspi_io_o  out  4  IO output
- qspi_io_i  in  4  IO input
- qspi_io_oe  out  1  1 = host drives IO

Behaviour:
- Reset (async, immediate, including mid-frame): state IDLE; sck=0, sce=1, io_o=0, io_oe=0, req_ready=1, busy=0, done=0, rd_valid=0, wr_ready=0, rd_data=0.
- States: IDLE -> START -> CMD -> ADDR -> [DUMMY] -> [DATA] -> END -> GAP -> IDLE.
- IDLE:
  - Request accepted on the clk where req_valid_i && req_ready_o; fields are latched.
  - req_ready_o drops the next cycle; sce falls the cycle after acceptance; busy_o=1.
- START: sce low, sck low, for CLKDIV cycles. First bit is driven at entry.
- SCK generation:
  - SCK toggles every CLKDIV clk cycles.
  - Outputs change only while SCK is low: at phase entry and on each falling edge.
  - qspi_io_i is sampled on the clk where SCK rises.
- CMD: 8 SCK cycles, single-line, MSB first on io_o[0]; io_o[3:1]=0; oe=1.
- ADDR: 8 SCK cycles, quad, MSB nibble first; oe=1.
- DUMMY:
  - Reads only, when DUMMY>0: oe=0 from the falling edge after the last address nibble, for DUMMY SCK cycles.
  - Writes skip DUMMY.
- DATA read:
  - oe=0; 4 SCK cycles per word, MSB nibble first.
  - rd_data_o updates with a one-cycle rd_valid_o pulse on the clk following the 4th rising edge.
  - No backpressure.
- DATA write:
  - At each word boundary (SCK low) the word is latched if wr_valid_i; wr_ready_o pulses that cycle.
  - If wr_valid_i=0, SCK holds low and sce stays low (stall) until valid.
  - Then 4 SCK cycles, MSB nibble first, oe=1.
- A word counter counts down from req_len_i; len 0 goes from ADDR/DUMMY directly to END.
- END: SCK low for CLKDIV cycles, then sce=1, oe=0, done_o pulse.
- GAP: sce held high CSHIGH cycles; then req_ready_o=1, busy_o=0.
- SCK cycles per frame:
  - Read: 8+8+DUMMY+4*len.
  - Write: 16+4*len, plus stall time.
- Simultaneous events: req_valid_i during a frame is ignored (not latched); wr_valid_i outside write DATA is ignored.

Optional Feature:
- QSPI_QUAD_CMD_EN defined: the command is sent in quad mode, 2 SCK cycles, high nibble first. Read SCK total becomes 2+8+DUMMY+4*len.
- QSPI_QUAD_CMD_EN undefined: the command is single-line, 8 SCK cycles, as above.

Test Plan:
- Reset mid-ADDR at CLKDIV=2 -> sce=1, sck=0, oe=0 in the same cycle; req_ready_o=1 once reset is released; no done_o.
- Read, cmd 0xEB, addr 0x0000_1234, len 1, DUMMY=8, CLKDIV=2, slave returns 0xBEEF:
  - io0 shows 11101011 over 8 SCK; address nibbles 0,0,0,0,1,2,3,4.
  - oe drops after the address; 28 SCK total.
  - rd_data_o=0xBEEF with a single rd_valid_o pulse; done_o pulses once.
- Write, cmd 0x02, addr 0x0001_0000, len 2, data 0xA5A5, 0x1234 presented immediately -> 24 SCK, oe=1 throughout, two wr_ready_o pulses, nibbles A,5,A,5,1,2,3,4.
- Same write with wr_valid_i withheld 20 clks before the 2nd word -> SCK low and sce low during the stall; frame resumes and completes with identical nibbles.
- Read len 0 -> 16+DUMMY SCK, no rd_valid_o; back-to-back request -> sce high >= CSHIGH cycles between frames.
- QSPI_QUAD_CMD_EN build, cmd 0xEB -> nibbles E,B over 2 SCK; 22 SCK for read len 1 with DUMMY=8.

Source files
------------

// File: rtl/qspi_host.sv
// ---------------------------------------------------------------------------
// qspi_host
//   QSPI initiator. Accepts one transaction request (command, 32-bit address,
//   direction, 16-bit word count) over a valid/ready handshake and produces
//   the complete QSPI frame: command, quad address, optional dummy clocks on
//   reads, and 16-bit data words (four nibbles each, MSB nibble first).
//   SPI mode 0: SCK idles low. Outputs change only while SCK is low, and
//   qspi_io_i is sampled on the clk where SCK rises.
//
//   Build option:
//     QSPI_QUAD_CMD_EN  defined   -> command sent quad, 2 SCK, high nibble first
//                       undefined -> command sent single-line on io[0], 8 SCK
//
//   Parameters:
//     CLKDIV   SCK half-period in clk_i cycles (>=1)
//     DUMMY    dummy SCK cycles before read data (0..31)
//     LENBITS  width of the word-count field
//     CSHIGH   minimum clk_i cycles SCE stays high between frames
//
//   Ports:
//     clk_i, reset_i           clock, asynchronous active-high reset
//     req_valid_i/req_ready_o  request handshake
//     req_cmd_i, req_addr_i    command byte, address
//     req_write_i, req_len_i   direction (1 = write), word count (0 = no data)
//     wr_data_i/wr_valid_i     write word source; wr_ready_o pulses on latch
//     rd_data_o/rd_valid_o     read word, rd_valid_o pulses when new
//     busy_o, done_o           frame in progress, pulse when SCE returns high
//     qspi_sck_o, qspi_sce_o   SPI clock, active-low chip enable
//     qspi_io_o/qspi_io_i      IO lines, qspi_io_oe = 1 when host drives
// ---------------------------------------------------------------------------
module qspi_host #(
    parameter int unsigned CLKDIV  = 2,
    parameter int unsigned DUMMY   = 8,
    parameter int unsigned LENBITS = 8,
    parameter int unsigned CSHIGH  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [7:0]         req_cmd_i,
    input  logic [31:0]        req_addr_i,
    input  logic               req_write_i,
    input  logic [LENBITS-1:0] req_len_i,
    input  logic [15:0]        wr_data_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    output logic [15:0]        rd_data_o,
    output logic               rd_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               qspi_sck_o,
    output logic               qspi_sce_o,
    output logic [3:0]         qspi_io_o,
    input  logic [3:0]         qspi_io_i,
    output logic               qspi_io_oe
);

    localparam logic [15:0] DIV_RELOAD = (CLKDIV > 1) ? 16'(CLKDIV - 1) : 16'd0;
    localparam logic [15:0] GAP_RELOAD = (CSHIGH > 1) ? 16'(CSHIGH - 1) : 16'd0;
    localparam logic [4:0]  DUMMY_LAST = (DUMMY > 0)  ? 5'(DUMMY - 1)   : 5'd0;
    localparam bit          HAS_DUMMY  = (DUMMY != 0);
`ifdef QSPI_QUAD_CMD_EN
    localparam logic [4:0]  CMD_LAST   = 5'd1;
`else
    localparam logic [4:0]  CMD_LAST   = 5'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_END,
        S_GAP
    } state_t;

    state_t             state_q;
    logic [15:0]        div_q;      // SCK half-period counter, reused as GAP timer
    logic [4:0]         bit_q;      // SCK cycles left in the current phase/word, minus one
    logic [LENBITS-1:0] len_q;      // data words still to transfer
    logic [31:0]        tx_q;       // outgoing bits, next to drive at the top
    logic [31:0]        addr_q;
    logic               write_q;
    logic               wait_q;     // write word boundary reached, waiting for wr_valid_i
    logic [11:0]        rx_q;       // nibbles of the read word received so far

    logic               req_ready_q;
    logic               wr_ready_q;
    logic [15:0]        rd_data_q;
    logic               rd_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               sck_q;
    logic               sce_q;
    logic [3:0]         io_q;
    logic               oe_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wait_q      <= 1'b0;
            rx_q        <= '0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sck_q       <= 1'b0;
            sce_q       <= 1'b1;
            io_q        <= '0;
            oe_q        <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            done_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        state_q     <= S_START;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        sce_q       <= 1'b0;
                        oe_q        <= 1'b1;
                        addr_q      <= req_addr_i;
                        write_q     <= req_write_i;
                        len_q       <= req_len_i;
                        wait_q      <= 1'b0;
                        div_q       <= DIV_RELOAD;
                        bit_q       <= CMD_LAST;
`ifdef QSPI_QUAD_CMD_EN
                        io_q        <= req_cmd_i[7:4];
                        tx_q        <= {req_cmd_i[3:0], 28'd0};
`else
                        io_q        <= {3'b000, req_cmd_i[7]};
                        tx_q        <= {req_cmd_i[6:0], 25'd0};
`endif
                    end
                end

                S_START: begin
                    if (div_q != '0) begin
                        div_q <= div_q - 16'd1;
                    end else begin
                        div_q   <= DIV_RELOAD;
                        sck_q   <= 1'b1;
                        state_q <= S_CMD;
                    end
                end

                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    if (state_q == S_DATA && wait_q) begin
                        // Stall with SCK low until the next write word shows up;
                        // the divider restarts so the first nibble gets a full
                        // low half-period of setup.
                        if (wr_valid_i) begin
                            io_q       <= wr_data_i[15:12];
                            tx_q       <= {wr_data_i[11:0], 20'd0};
                            wr_ready_q <= 1'b1;
                            wait_q     <= 1'b0;
                            div_q      <= DIV_RELOAD;
                        end
                    end else if (div_q != '0) begin
                        div_q <= div_q - 16'd1;
                    end else if (!sck_q) begin
                        // Rising edge: sample read data.
                        div_q <= DIV_RELOAD;
                        sck_q <= 1'b1;
                        if (state_q == S_DATA && !write_q) begin
                            rx_q <= {rx_q[7:0], qspi_io_i};
                            if (bit_q == '0) begin
                                rd_data_q  <= {rx_q, qspi_io_i};
                                rd_valid_q <= 1'b1;
                            end
                        end
                    end else begin
                        // Falling edge: drive the next bits or move to the next phase.
                        div_q <= DIV_RELOAD;
                        sck_q <= 1'b0;
                        if (bit_q != '0) begin
                            bit_q <= bit_q - 5'd1;
                            case (state_q)
                                S_CMD: begin
`ifdef QSPI_QUAD_CMD_EN
                                    io_q <= tx_q[31:28];
                                    tx_q <= {tx_q[27:0], 4'd0};
`else
                                    io_q <= {3'b000, tx_q[31]};
                                    tx_q <= {tx_q[30:0], 1'b0};
`endif
                                end
                                S_ADDR, S_DATA: begin
                                    if (state_q == S_ADDR || write_q) begin
                                        io_q <= tx_q[31:28];
                                        tx_q <= {tx_q[27:0], 4'd0};
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            case (state_q)
                                S_CMD: begin
                                    state_q <= S_ADDR;
                                    bit_q   <= 5'd7;
                                    io_q    <= addr_q[31:28];
                                    tx_q    <= {addr_q[27:0], 4'd0};
                                end
                                S_ADDR, S_DUMMY: begin
                                    if (state_q == S_ADDR && !write_q && HAS_DUMMY) begin
                                        state_q <= S_DUMMY;
                                        bit_q   <= DUMMY_LAST;
                                        oe_q    <= 1'b0;
                                        io_q    <= '0;
                                    end else if (len_q == '0) begin
                                        state_q <= S_END;
                                    end else begin
                                        state_q <= S_DATA;
                                        bit_q   <= 5'd3;
                                        if (write_q) begin
                                            oe_q   <= 1'b1;
                                            wait_q <= 1'b1;
                                        end else begin
                                            oe_q <= 1'b0;
                                            io_q <= '0;
                                        end
                                    end
                                end
                                S_DATA: begin
                                    len_q <= len_q - 1'b1;
                                    if (len_q == LENBITS'(1)) begin
                                        state_q <= S_END;
                                    end else begin
                                        bit_q  <= 5'd3;
                                        wait_q <= write_q;
                                    end
                                end
                                default: state_q <= S_END;
                            endcase
                        end
                    end
                end

                S_END: begin
                    if (div_q != '0) begin
                        div_q <= div_q - 16'd1;
                    end else begin
                        state_q <= S_GAP;
                        sce_q   <= 1'b1;
                        oe_q    <= 1'b0;
                        io_q    <= '0;
                        done_q  <= 1'b1;
                        div_q   <= GAP_RELOAD;
                    end
                end

                S_GAP: begin
                    if (div_q != '0) begin
                        div_q <= div_q - 16'd1;
                    end else begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    sce_q       <= 1'b1;
                    sck_q       <= 1'b0;
                    oe_q        <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign wr_ready_o  = wr_ready_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign qspi_sck_o  = sck_q;
    assign qspi_sce_o  = sce_q;
    assign qspi_io_o   = io_q;
    assign qspi_io_oe  = oe_q;

endmodule

// File: tb/tb_qspi_host.sv
// ---------------------------------------------------------------------------
// tb_qspi_host
//   Directed and randomized frames against qspi_host. A bus monitor records
//   (oe, io) at every SCK rising edge of a frame, a slave model returns read
//   nibbles by SCK index, and each frame is compared against the expected
//   bit stream derived from the transaction fields.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qspi_host;

    localparam int CLKDIV  = 2;
    localparam int DUMMY   = 8;
    localparam int LENBITS = 8;
    localparam int CSHIGH  = 4;
`ifdef QSPI_QUAD_CMD_EN
    localparam int CMDCYC  = 2;
`else
    localparam int CMDCYC  = 8;
`endif

    logic               clk = 1'b0;
    logic               reset_i;
    logic               req_valid_i;
    logic               req_ready_o;
    logic [7:0]         req_cmd_i;
    logic [31:0]        req_addr_i;
    logic               req_write_i;
    logic [LENBITS-1:0] req_len_i;
    logic [15:0]        wr_data_i;
    logic               wr_valid_i;
    logic               wr_ready_o;
    logic [15:0]        rd_data_o;
    logic               rd_valid_o;
    logic               busy_o;
    logic               done_o;
    logic               qspi_sck_o;
    logic               qspi_sce_o;
    logic [3:0]         qspi_io_o;
    logic [3:0]         qspi_io_i;
    logic               qspi_io_oe;

    qspi_host #(
        .CLKDIV  (CLKDIV),
        .DUMMY   (DUMMY),
        .LENBITS (LENBITS),
        .CSHIGH  (CSHIGH)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cmd_i   (req_cmd_i),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_len_i   (req_len_i),
        .wr_data_i   (wr_data_i),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .qspi_sck_o  (qspi_sck_o),
        .qspi_sce_o  (qspi_sce_o),
        .qspi_io_o   (qspi_io_o),
        .qspi_io_i   (qspi_io_i),
        .qspi_io_oe  (qspi_io_oe)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Current transaction, shared with the monitor/slave.
    logic [7:0]  cur_cmd;
    logic [31:0] cur_addr;
    logic        cur_write = 1'b0;
    int          cur_len   = 0;
    logic [15:0] cur_words [4];

    // Bus monitor and slave model, all sampled away from the active edge.
    logic [3:0] mon_io [$];
    logic       mon_oe [$];
    int         rises    = 0;
    int         stab_err = 0;
    int         hi_run   = 0;
    int         last_gap = 0;
    logic       prev_sck = 1'b0;
    logic       prev_sce = 1'b1;
    logic [3:0] rise_io;
    logic       rise_oe;

    always @(negedge clk) begin
        int          idx;
        logic [15:0] w;
        if (!qspi_sce_o) begin
            if (prev_sce) begin
                last_gap = hi_run;
                hi_run   = 0;
            end
            if (qspi_sck_o && !prev_sck) begin
                mon_io.push_back(qspi_io_o);
                mon_oe.push_back(qspi_io_oe);
                rise_io = qspi_io_o;
                rise_oe = qspi_io_oe;
                rises++;
            end else if (qspi_sck_o) begin
                if (qspi_io_o !== rise_io || qspi_io_oe !== rise_oe) stab_err++;
            end
            if (!qspi_sck_o) begin
                idx = rises - (CMDCYC + 8 + DUMMY);
                if (!cur_write && idx >= 0 && idx < 4 * cur_len) begin
                    w = cur_words[idx / 4] >> (12 - 4 * (idx % 4));
                    qspi_io_i = w[3:0];
                end else begin
                    qspi_io_i = 4'h0;
                end
            end
        end else begin
            hi_run++;
            qspi_io_i = 4'h0;
        end
        prev_sck = qspi_sck_o;
        prev_sce = qspi_sce_o;
    end

    // Run one frame. stall_word: withhold wr_valid_i for stall_len cycles
    // before that word (index >= len means never).
    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic wr, input int len,
                            input int stall_word, input int stall_len,
                            input bit chk_stall);
        int          n;
        int          cyc;
        int          done_n;
        int          rd_n;
        int          wr_n;
        int          wi;
        int          stall_cnt;
        int          exp_rises;
        int          j;
        logic        exp_oe;
        logic [3:0]  exp_io;
        logic [31:0] t32;
        logic [15:0] t16;

        @(negedge clk);
        cur_cmd   = cmd;
        cur_addr  = addr;
        cur_write = wr;
        cur_len   = len;
        mon_io.delete();
        mon_oe.delete();
        rises     = 0;
        stab_err  = 0;

        req_cmd_i   = cmd;
        req_addr_i  = addr;
        req_write_i = wr;
        req_len_i   = LENBITS'(len);
        req_valid_i = 1'b1;
        wi          = 0;
        stall_cnt   = (stall_word == 0) ? stall_len : 0;
        wr_data_i   = cur_words[0];
        wr_valid_i  = wr && (len > 0) && (stall_cnt == 0);

        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", req_ready_o, 1'b1);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("ready_drops", req_ready_o, 1'b0);
        chk("busy_after_accept", busy_o, 1'b1);
        chk("sce_falls", qspi_sce_o, 1'b0);

        done_n = 0; rd_n = 0; wr_n = 0; cyc = 0;
        while (done_n == 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (rd_valid_o) begin
                if (rd_n < 4) chk($sformatf("rd_data[%0d]", rd_n), rd_data_o, cur_words[rd_n]);
                rd_n++;
            end
            if (wr_ready_o) begin
                wr_n++;
                wi++;
                if (wi < 4) wr_data_i = cur_words[wi];
                if (wi == stall_word) stall_cnt = stall_len;
            end else if (stall_cnt > 0) begin
                if (chk_stall && stall_cnt == 1) begin
                    chk("stall_sck_low", qspi_sck_o, 1'b0);
                    chk("stall_sce_low", qspi_sce_o, 1'b0);
                end
                stall_cnt--;
            end
            wr_valid_i = wr && (wi < len) && (stall_cnt == 0);
            if (done_o) done_n++;
        end
        wr_valid_i = 1'b0;

        chk("done_pulse", done_n, 1);
        chk("sce_high_at_done", qspi_sce_o, 1'b1);
        chk("busy_in_gap", busy_o, 1'b1);
        exp_rises = CMDCYC + 8 + (wr ? 0 : DUMMY) + 4 * len;
        chk("sck_count", rises, exp_rises);
        chk("rd_valid_pulses", rd_n, wr ? 0 : len);
        chk("wr_ready_pulses", wr_n, wr ? len : 0);
        chk("io_stable_sck_high", stab_err, 0);
        chk("sce_gap_min", (last_gap >= CSHIGH), 1'b1);

        for (int k = 0; k < rises && k < exp_rises; k++) begin
            exp_oe = 1'b1;
            exp_io = 4'h0;
            if (k < CMDCYC) begin
`ifdef QSPI_QUAD_CMD_EN
                exp_io = (k == 0) ? cmd[7:4] : cmd[3:0];
`else
                exp_io = {3'b000, cmd[7 - k]};
`endif
            end else if (k < CMDCYC + 8) begin
                j      = k - CMDCYC;
                t32    = addr >> (28 - 4 * j);
                exp_io = t32[3:0];
            end else if (!wr) begin
                exp_oe = 1'b0;
            end else begin
                j      = k - CMDCYC - 8;
                t16    = cur_words[j / 4] >> (12 - 4 * (j % 4));
                exp_io = t16[3:0];
            end
            chk($sformatf("oe[%0d]", k), mon_oe[k], exp_oe);
            if (exp_oe) chk($sformatf("io[%0d]", k), mon_io[k], exp_io);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dn;

        reset_i     = 1'b1;
        req_valid_i = 1'b0;
        req_cmd_i   = '0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_len_i   = '0;
        wr_data_i   = '0;
        wr_valid_i  = 1'b0;
        qspi_io_i   = '0;
        for (int i = 0; i < 4; i++) cur_words[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_sce", qspi_sce_o, 1'b1);
        chk("rst_sck", qspi_sck_o, 1'b0);
        chk("rst_oe", qspi_io_oe, 1'b0);
        chk("rst_io", qspi_io_o, 4'h0);
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_rd_valid", rd_valid_o, 1'b0);
        chk("rst_wr_ready", wr_ready_o, 1'b0);
        chk("rst_rd_data", rd_data_o, 16'h0000);

        // Read 0xEB @ 0x1234, one word 0xBEEF.
        cur_words[0] = 16'hBEEF;
        do_frame(8'hEB, 32'h0000_1234, 1'b0, 1, 9, 0, 1'b0);

        // Write two words presented immediately.
        cur_words[0] = 16'hA5A5;
        cur_words[1] = 16'h1234;
        do_frame(8'h02, 32'h0001_0000, 1'b1, 2, 9, 0, 1'b0);

        // Same write, 2nd word withheld 20 clks.
        do_frame(8'h02, 32'h0001_0000, 1'b1, 2, 1, 20, 1'b1);

        // Zero-length reads, back-to-back.
        do_frame(8'h9F, 32'hDEAD_BEEF, 1'b0, 0, 9, 0, 1'b0);
        do_frame(8'h05, 32'h0F0F_0F0F, 1'b0, 0, 9, 0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 4; i++) cur_words[i] = 16'($urandom);
            do_frame(8'($urandom), $urandom, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(1, 25), 1'b0);
        end

        // Reset in the middle of the address phase.
        @(negedge clk);
        cur_write   = 1'b0;
        cur_len     = 1;
        rises       = 0;
        req_cmd_i   = 8'hEB;
        req_addr_i  = 32'h1234_5678;
        req_write_i = 1'b0;
        req_len_i   = LENBITS'(1);
        req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        while (rises < CMDCYC + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_addr", (rises >= CMDCYC + 2), 1'b1);
        reset_i = 1'b1;
        #1;
        chk("midrst_sce", qspi_sce_o, 1'b1);
        chk("midrst_sck", qspi_sck_o, 1'b0);
        chk("midrst_oe", qspi_io_oe, 1'b0);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("midrst_ready", req_ready_o, 1'b1);
        chk("midrst_busy", busy_o, 1'b0);
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_o) dn++;
        end
        chk("midrst_no_done", dn, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
